// File: rtl/vga_timing_gen.sv
// vga_timing_gen: raster position, sync/blank strobes, frame-start pulse and
// frame counter for the pixel pipeline. Advances one pixel per clock with
// pix_en high. Every output is registered and computed from the next counter
// values, so sync/blank stay cycle-aligned with hcount/vcount.
// Both H_TOTAL and V_TOTAL must not exceed 2048 (11-bit counters).
module vga_timing_gen #(
    parameter int H_ACTIVE        = 640,
    parameter int H_FP            = 16,
    parameter int H_SYNC          = 96,
    parameter int H_BP            = 48,
    parameter int V_ACTIVE        = 480,
    parameter int V_FP            = 10,
    parameter int V_SYNC          = 2,
    parameter int V_BP            = 33,
    parameter bit SYNC_ACTIVE_LOW = 1'b1
) (
    input  logic        clk,
    input  logic        rst,          // asynchronous, active-low
    input  logic        pix_en,
    output logic [10:0] hcount,
    output logic [10:0] vcount,
    output logic        hsync,
    output logic        vsync,
    output logic        hblnk,
    output logic        vblnk,
    output logic        blank,
    output logic        frame_start,
    output logic [15:0] frame_cnt
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST = 11'(V_TOTAL - 1);

    // Boundaries held one bit wider so an end value of 2048 does not wrap.
    localparam logic [11:0] H_BLANK_START = 12'(H_ACTIVE);
    localparam logic [11:0] H_SYNC_START  = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0] H_SYNC_STOP   = 12'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [11:0] V_BLANK_START = 12'(V_ACTIVE);
    localparam logic [11:0] V_SYNC_START  = 12'(V_ACTIVE + V_FP);
    localparam logic [11:0] V_SYNC_STOP   = 12'(V_ACTIVE + V_FP + V_SYNC);

    localparam logic SYNC_ON  = SYNC_ACTIVE_LOW ? 1'b0 : 1'b1;
    localparam logic SYNC_OFF = SYNC_ACTIVE_LOW ? 1'b1 : 1'b0;

    typedef struct packed {
        logic [10:0] hcount;
        logic [10:0] vcount;
        logic        hsync;
        logic        vsync;
        logic        hblnk;
        logic        vblnk;
        logic        blank;
        logic        frame_start;
        logic [15:0] frame_cnt;
    } timing_t;

    localparam timing_t RESET_STATE = '{
        hcount:      11'd0,
        vcount:      11'd0,
        hsync:       SYNC_OFF,
        vsync:       SYNC_OFF,
        hblnk:       1'b0,
        vblnk:       1'b0,
        blank:       1'b0,
        frame_start: 1'b0,
        frame_cnt:   16'd0
    };

    timing_t state_q;
    timing_t state_d;
    logic    h_wrap;
    logic    v_wrap;
    logic    hblnk_d;
    logic    vblnk_d;

    assign h_wrap = (state_q.hcount == H_LAST);
    assign v_wrap = (state_q.vcount == V_LAST);

    // Next position and the strobes decoded from that next position.
    always_comb begin
        // NOTE: every field gets a default (hold) before any branch, so no latch is inferred.
        state_d             = state_q;
        state_d.frame_start = 1'b0;
        hblnk_d             = state_q.hblnk;
        vblnk_d             = state_q.vblnk;
        if (pix_en) begin
            state_d.hcount = h_wrap ? 11'd0 : state_q.hcount + 11'd1;
            if (h_wrap) begin
                state_d.vcount = v_wrap ? 11'd0 : state_q.vcount + 11'd1;
            end

            hblnk_d = ({1'b0, state_d.hcount} >= H_BLANK_START);
            vblnk_d = ({1'b0, state_d.vcount} >= V_BLANK_START);

            state_d.hsync = ({1'b0, state_d.hcount} >= H_SYNC_START &&
                             {1'b0, state_d.hcount} <  H_SYNC_STOP) ? SYNC_ON : SYNC_OFF;
            // vsync follows vcount alone; it is not gated by the line position.
            state_d.vsync = ({1'b0, state_d.vcount} >= V_SYNC_START &&
                             {1'b0, state_d.vcount} <  V_SYNC_STOP) ? SYNC_ON : SYNC_OFF;

            state_d.hblnk = hblnk_d;
            state_d.vblnk = vblnk_d;
            state_d.blank = hblnk_d | vblnk_d;

            // Frame wrap: last pixel of the last line steps back to (0,0).
            state_d.frame_start = h_wrap & v_wrap;
            if (h_wrap && v_wrap) begin
                state_d.frame_cnt = state_q.frame_cnt + 16'd1;
            end
        end
    end

    // Output register bank with asynchronous return to the reset state.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking assignment so all fields update together at the edge.
        if (!rst) begin
            state_q <= RESET_STATE;
        end else begin
            state_q <= state_d;
        end
    end

    assign hcount      = state_q.hcount;
    assign vcount      = state_q.vcount;
    assign hsync       = state_q.hsync;
    assign vsync       = state_q.vsync;
    assign hblnk       = state_q.hblnk;
    assign vblnk       = state_q.vblnk;
    assign blank       = state_q.blank;
    assign frame_start = state_q.frame_start;
    assign frame_cnt   = state_q.frame_cnt;

endmodule
